// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin owner of the shared Ethernet TX shifter.
// Grants one response source per frame, then enforces an inter-frame gap.
module eth_tx_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int IFG_TICKS   = 12,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ARB_EN,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               OUT_TICK,
  input  logic               TX_BUSY,
  input  logic               TX_DONE,
  input  logic               ERR_CLR,
  output logic [NUM_REQ-1:0] GNT,
  output logic [2:0]         GNT_IDX,
  output logic               TX_START,
  output logic               ARB_BUSY,
  output logic               TIMEOUT_ERR,
  output logic [15:0]        FRAME_CNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST =
    (IFG_TICKS == 0) ? 16'd0 : 16'(IFG_TICKS - 1);

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         rr_q, rr_d;
  logic               start_q, start_d;
  logic               busy_q;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        wd_q, wd_d;
  logic [15:0]        gap_q, gap_d;

  logic [7:0]         req_pad;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [3:0]         idx_inc;
  logic [2:0]         rr_nxt;
  logic [15:0]        wd_inc;

  assign req_pad    = 8'(REQ);
  assign sel_onehot = NUM_REQ'(1) << sel_idx;
  assign idx_inc    = {1'b0, idx_q} + 4'd1;
  assign rr_nxt     = (idx_inc >= 4'(NUM_REQ)) ? 3'd0 : idx_inc[2:0];
  assign wd_inc     = wd_q + 16'd1;

  // first requester at or after the round-robin pointer, wrapping
  always_comb begin
    logic [3:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!sel_found && req_pad[cand[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  // frame sequencing, watchdog and gap counting
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    start_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    if (ERR_CLR) err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ARB_EN && sel_found) begin
          gnt_d   = sel_onehot;
          idx_d   = sel_idx;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT, S_SEND: begin
        if (TX_DONE) begin
          gnt_d   = '0;
          cnt_d   = cnt_q + 16'd1;
          rr_d    = rr_nxt;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (wd_inc == WD_LAST) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          rr_d    = rr_nxt;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_inc;
          if (state_q == S_WAIT && TX_BUSY) state_d = S_SEND;
        end
      end
      S_GAP: begin
        if (IFG_TICKS == 0) begin
          state_d = S_IDLE;
        end else if (OUT_TICK) begin
          if (gap_q == GAP_LAST) state_d = S_IDLE;
          else gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      start_q <= start_d;
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign GNT         = gnt_q;
  assign GNT_IDX     = idx_q;
  assign TX_START    = start_q & RESET_N;
  assign ARB_BUSY    = busy_q;
  assign TIMEOUT_ERR = err_q;
  assign FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed scenarios for the TX arbiter.
// dut has a 12-tick gap, dut0 a zero gap; both use a 16-cycle watchdog.
module tb_eth_tx_arbiter;

  logic CLK = 1'b0;
  logic RESET_N, ARB_EN, OUT_TICK, TX_BUSY, TX_DONE, ERR_CLR;
  logic [4:0] REQ;
  logic [4:0] GNT, gnt0;
  logic [2:0] GNT_IDX, idx0;
  logic TX_START, ARB_BUSY, TIMEOUT_ERR;
  logic start0, abusy0, err0;
  logic [15:0] FRAME_CNT, cnt0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  eth_tx_arbiter #(.NUM_REQ(5), .IFG_TICKS(12), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ARB_EN(ARB_EN), .REQ(REQ),
    .OUT_TICK(OUT_TICK), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE),
    .ERR_CLR(ERR_CLR), .GNT(GNT), .GNT_IDX(GNT_IDX),
    .TX_START(TX_START), .ARB_BUSY(ARB_BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .FRAME_CNT(FRAME_CNT));

  eth_tx_arbiter #(.NUM_REQ(5), .IFG_TICKS(0), .TIMEOUT_CYC(16)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .ARB_EN(ARB_EN), .REQ(REQ),
    .OUT_TICK(OUT_TICK), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE),
    .ERR_CLR(ERR_CLR), .GNT(gnt0), .GNT_IDX(idx0),
    .TX_START(start0), .ARB_BUSY(abusy0),
    .TIMEOUT_ERR(err0), .FRAME_CNT(cnt0));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  // from START: busy, done, land in GAP
  task automatic send_frame();
    tick();
    TX_BUSY = 1'b1;
    tick();
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    TX_BUSY = 1'b0;
  endtask

  task automatic gap(input int n);
    OUT_TICK = 1'b1;
    repeat (n) tick();
    OUT_TICK = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (GNT !== 5'b0 || GNT_IDX !== 3'd0 || TX_START !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gnt got gnt=%b idx=%0d st=%b exp 0/0/0",
               GNT, GNT_IDX, TX_START);
    end
    n_checks++;
    if (ARB_BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b0 || FRAME_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_stat got busy=%b err=%b cnt=%0d exp 0/0/0",
               ARB_BUSY, TIMEOUT_ERR, FRAME_CNT);
    end
  endtask

  task automatic test_single();
    ARB_EN = 1'b1;
    REQ = 5'b00100;
    tick();
    n_checks++;
    if (GNT !== 5'b00100 || GNT_IDX !== 3'd2 || TX_START !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_grant got gnt=%b idx=%0d st=%b exp 00100/2/1",
               GNT, GNT_IDX, TX_START);
    end
    tick();
    n_checks++;
    if (TX_START !== 1'b0 || GNT !== 5'b00100) begin
      n_fail++;
      $display("FAIL t1_pulse got st=%b gnt=%b exp 0/00100", TX_START, GNT);
    end
    TX_BUSY = 1'b1;
    tick();
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    TX_BUSY = 1'b0;
    n_checks++;
    if (GNT !== 5'b0 || FRAME_CNT !== 16'd1 || GNT_IDX !== 3'd2) begin
      n_fail++;
      $display("FAIL t1_done got gnt=%b cnt=%0d idx=%0d exp 0/1/2",
               GNT, FRAME_CNT, GNT_IDX);
    end
    n_checks++;
    if (ARB_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_gapbusy got %b exp 1", ARB_BUSY);
    end
    OUT_TICK = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if (GNT !== 5'b0 || TX_START !== 1'b0) begin
        n_fail++;
        $display("FAIL t1_gap%0d got gnt=%b st=%b exp 0/0", i, GNT, TX_START);
      end
    end
    tick();
    OUT_TICK = 1'b0;
    n_checks++;
    if (ARB_BUSY !== 1'b0 || GNT !== 5'b0) begin
      n_fail++;
      $display("FAIL t1_idle got busy=%b gnt=%b exp 0/0", ARB_BUSY, GNT);
    end
    tick();
    n_checks++;
    if (GNT !== 5'b00100 || TX_START !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_regrant got gnt=%b st=%b exp 00100/1", GNT, TX_START);
    end
    send_frame();
    gap(12);
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] exp_g;
    do_reset();
    ARB_EN = 1'b1;
    REQ = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = 5'b00001 << order[k];
      n_checks++;
      if (GNT_IDX !== 3'(order[k]) || GNT !== exp_g) begin
        n_fail++;
        $display("FAIL t2_order%0d got idx=%0d gnt=%b exp %0d/%b",
                 k, GNT_IDX, GNT, order[k], exp_g);
      end
      send_frame();
      gap(12);
    end
    n_checks++;
    if (FRAME_CNT !== 16'd6) begin
      n_fail++;
      $display("FAIL t2_cnt got %0d exp 6", FRAME_CNT);
    end
  endtask

  task automatic test_zero_gap();
    do_reset();
    ARB_EN = 1'b1;
    REQ = 5'b00011;
    tick();
    n_checks++;
    if (gnt0 !== 5'b00001 || start0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_first got gnt=%b st=%b exp 00001/1", gnt0, start0);
    end
    send_frame();
    n_checks++;
    if (gnt0 !== 5'b0 || abusy0 !== 1'b1 || start0 !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_gap got gnt=%b busy=%b st=%b exp 0/1/0",
               gnt0, abusy0, start0);
    end
    tick();
    n_checks++;
    if (abusy0 !== 1'b0 || start0 !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_idle got busy=%b st=%b exp 0/0", abusy0, start0);
    end
    tick();
    n_checks++;
    if (gnt0 !== 5'b00010 || idx0 !== 3'd1 || start0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_second got gnt=%b idx=%0d st=%b exp 00010/1/1",
               gnt0, idx0, start0);
    end
    send_frame();
    n_checks++;
    if (cnt0 !== 16'd2) begin
      n_fail++;
      $display("FAIL t3_cnt got %0d exp 2", cnt0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ARB_EN = 1'b1;
    REQ = 5'b01000;
    tick();
    n_checks++;
    if (GNT !== 5'b01000 || GNT_IDX !== 3'd3) begin
      n_fail++;
      $display("FAIL t4_grant got gnt=%b idx=%0d exp 01000/3", GNT, GNT_IDX);
    end
    repeat (15) tick();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0 || GNT !== 5'b01000) begin
      n_fail++;
      $display("FAIL t4_early got err=%b gnt=%b exp 0/01000",
               TIMEOUT_ERR, GNT);
    end
    tick();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1 || GNT !== 5'b0 || FRAME_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL t4_abort got err=%b gnt=%b cnt=%0d exp 1/0/0",
               TIMEOUT_ERR, GNT, FRAME_CNT);
    end
    REQ = 5'b11000;
    gap(12);
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_sticky got %b exp 1", TIMEOUT_ERR);
    end
    tick();
    n_checks++;
    if (GNT !== 5'b10000 || GNT_IDX !== 3'd4) begin
      n_fail++;
      $display("FAIL t4_next got gnt=%b idx=%0d exp 10000/4", GNT, GNT_IDX);
    end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_clr got %b exp 0", TIMEOUT_ERR);
    end
    repeat (14) tick();
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0 || FRAME_CNT !== 16'd1 || GNT !== 5'b0) begin
      n_fail++;
      $display("FAIL t4_race got err=%b cnt=%0d gnt=%b exp 0/1/0",
               TIMEOUT_ERR, FRAME_CNT, GNT);
    end
  endtask

  task automatic test_reset_mid();
    gap(12);
    REQ = 5'b01000;
    tick();
    n_checks++;
    if (GNT !== 5'b01000 || TX_START !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_grant got gnt=%b st=%b exp 01000/1", GNT, TX_START);
    end
    tick();
    TX_BUSY = 1'b1;
    tick();
    RESET_N = 1'b0;
    tick();
    n_checks++;
    if (GNT !== 5'b0 || GNT_IDX !== 3'd0 || TX_START !== 1'b0 ||
        ARB_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_rst got gnt=%b idx=%0d st=%b busy=%b exp 0/0/0/0",
               GNT, GNT_IDX, TX_START, ARB_BUSY);
    end
    n_checks++;
    if (FRAME_CNT !== 16'd0 || TIMEOUT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_rstcnt got cnt=%0d err=%b exp 0/0",
               FRAME_CNT, TIMEOUT_ERR);
    end
    RESET_N = 1'b1;
    TX_BUSY = 1'b0;
    tick();
    n_checks++;
    if (GNT !== 5'b01000 || GNT_IDX !== 3'd3 || TX_START !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_regrant got gnt=%b idx=%0d st=%b exp 01000/3/1",
               GNT, GNT_IDX, TX_START);
    end
  endtask

  task automatic test_arb_disable();
    tick();
    TX_BUSY = 1'b1;
    tick();
    REQ = 5'b00000;
    tick();
    n_checks++;
    if (GNT !== 5'b01000) begin
      n_fail++;
      $display("FAIL t6_hold got %b exp 01000", GNT);
    end
    ARB_EN = 1'b0;
    REQ = 5'b11111;
    TX_DONE = 1'b1;
    tick();
    TX_DONE = 1'b0;
    TX_BUSY = 1'b0;
    n_checks++;
    if (GNT !== 5'b0 || FRAME_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL t6_done got gnt=%b cnt=%0d exp 0/1", GNT, FRAME_CNT);
    end
    gap(12);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (TX_START !== 1'b0 || GNT !== 5'b0) begin
        n_fail++;
        $display("FAIL t6_block%0d got st=%b gnt=%b exp 0/0",
                 i, TX_START, GNT);
      end
    end
    ARB_EN = 1'b1;
    tick();
    n_checks++;
    if (GNT !== 5'b10000 || GNT_IDX !== 3'd4 || TX_START !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_resume got gnt=%b idx=%0d st=%b exp 10000/4/1",
               GNT, GNT_IDX, TX_START);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    ARB_EN = 1'b0;
    REQ = '0;
    OUT_TICK = 1'b0;
    TX_BUSY = 1'b0;
    TX_DONE = 1'b0;
    ERR_CLR = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_gap();
    test_timeout();
    test_reset_mid();
    test_arb_disable();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
